// File: rtl/mfsk_modulator.sv
// M-ary FSK modulator: serial bits -> symbols -> phase-continuous DDS phase address.
// Optional macro MFSK_GRAY_EN decodes each assembled symbol from Gray code before use.
module mfsk_modulator #(
    parameter int BITS_PER_SYM = 1,
    parameter int FTW_W        = 24,
    parameter int PHASE_OUT_W  = 10,
    parameter int SYM_CYCLES   = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    ftw_wr,
    input  logic [BITS_PER_SYM-1:0] ftw_addr,
    input  logic [FTW_W-1:0]        ftw_data,
    input  logic                    m_ser_code_in,
    input  logic                    m_ser_valid,
    output logic                    m_ser_ready,
    output logic [PHASE_OUT_W-1:0]  fsk_phase_out,
    output logic [BITS_PER_SYM-1:0] fsk_sym_idx_out,
    output logic                    fsk_sym_strobe,
    output logic                    fsk_busy,
    output logic                    fsk_underrun
);
    localparam int M     = 1 << BITS_PER_SYM;
    localparam int CNT_W = $clog2(SYM_CYCLES);
    localparam int BC_W  = $clog2(BITS_PER_SYM + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_CYCLES - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BITS_PER_SYM - 1);

    function automatic logic [BITS_PER_SYM-1:0] sym_decode(input logic [BITS_PER_SYM-1:0] g);
        logic [BITS_PER_SYM-1:0] b;
        b = g;
`ifdef MFSK_GRAY_EN
        for (int i = BITS_PER_SYM - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
`endif
        return b;
    endfunction

    logic [FTW_W-1:0]        ftw_q [M];
    logic [FTW_W-1:0]        phase_acc_q, phase_acc_d;
    logic [PHASE_OUT_W-1:0]  phase_out_q, phase_out_d;
    logic [CNT_W-1:0]        sym_cnt_q, sym_cnt_d;
    logic [BITS_PER_SYM-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic                    next_full_q, next_full_d;
    logic [BITS_PER_SYM-1:0] cur_idx_q, cur_idx_d;
    logic                    strobe_q, strobe_d;
    logic                    busy_q, busy_d;
    logic                    underrun_q, underrun_d;
    logic                    accept_s, boundary_s;
    logic [BITS_PER_SYM:0]   sh_ext_s;

    // Ready is forced low while reset is asserted so every output reads 0 during reset.
    assign m_ser_ready     = en & ~next_full_q & rst_n;
    assign fsk_phase_out   = phase_out_q;
    assign fsk_sym_idx_out = cur_idx_q;
    assign fsk_sym_strobe  = strobe_q;
    assign fsk_busy        = busy_q;
    assign fsk_underrun    = underrun_q;

    // FTW table: writes are independent of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < M; i++) begin
                ftw_q[i] <= '0;
            end
        end else if (ftw_wr) begin
            ftw_q[ftw_addr] <= ftw_data;
        end
    end

    // Next-state: symbol timer, bit intake, symbol transfer and phase accumulation.
    always_comb begin
        accept_s    = m_ser_valid & m_ser_ready;
        boundary_s  = en & (sym_cnt_q == CNT_LAST);
        sh_ext_s    = {shreg_q, m_ser_code_in};
        sym_cnt_d   = sym_cnt_q;
        phase_acc_d = phase_acc_q;
        phase_out_d = phase_out_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        next_full_d = next_full_q;
        cur_idx_d   = cur_idx_q;
        busy_d      = busy_q;
        strobe_d    = 1'b0;
        underrun_d  = 1'b0;

        if (en) begin
            sym_cnt_d   = boundary_s ? '0 : sym_cnt_q + CNT_W'(1);
            phase_acc_d = phase_acc_q + ftw_q[cur_idx_q];
            phase_out_d = phase_acc_q[FTW_W-1 -: PHASE_OUT_W];
        end else begin
            sym_cnt_d   = sym_cnt_q;
        end

        if (accept_s) begin
            shreg_d = sh_ext_s[BITS_PER_SYM-1:0];
            if (bit_cnt_q == BC_LAST) begin
                bit_cnt_d   = '0;
                next_full_d = 1'b1;
            end else begin
                bit_cnt_d   = bit_cnt_q + BC_W'(1);
            end
        end else begin
            shreg_d = shreg_q;
        end

        // Accept and transfer never coincide: ready is low whenever next_full is set.
        if (boundary_s) begin
            if (next_full_q) begin
                cur_idx_d   = sym_decode(shreg_q);
                next_full_d = 1'b0;
                strobe_d    = 1'b1;
                busy_d      = 1'b1;
            end else begin
                cur_idx_d   = '0;
                busy_d      = 1'b0;
                underrun_d  = 1'b1;
            end
        end else begin
            cur_idx_d = cur_idx_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_acc_q <= '0;
            phase_out_q <= '0;
            sym_cnt_q   <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            next_full_q <= 1'b0;
            cur_idx_q   <= '0;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            phase_acc_q <= phase_acc_d;
            phase_out_q <= phase_out_d;
            sym_cnt_q   <= sym_cnt_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            next_full_q <= next_full_d;
            cur_idx_q   <= cur_idx_d;
            strobe_q    <= strobe_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
        end
    end
endmodule

// File: tb/tb_mfsk_modulator.sv
// Self-checking bench for mfsk_modulator (BITS_PER_SYM=2, SYM_CYCLES=8) against a queue-based model.
module tb_mfsk_modulator;
    localparam int B  = 2;
    localparam int FW = 24;
    localparam int PW = 10;
    localparam int SC = 8;

    logic          clk = 1'b0;
    logic          rst_n, en, ftw_wr, m_ser_code_in, m_ser_valid, m_ser_ready;
    logic [B-1:0]  ftw_addr;
    logic [FW-1:0] ftw_data;
    logic [PW-1:0] fsk_phase_out;
    logic [B-1:0]  fsk_sym_idx_out;
    logic          fsk_sym_strobe, fsk_busy, fsk_underrun;

    always #5 clk = ~clk;

    mfsk_modulator #(.BITS_PER_SYM(B), .FTW_W(FW), .PHASE_OUT_W(PW), .SYM_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ftw_wr(ftw_wr), .ftw_addr(ftw_addr),
        .ftw_data(ftw_data), .m_ser_code_in(m_ser_code_in), .m_ser_valid(m_ser_valid),
        .m_ser_ready(m_ser_ready), .fsk_phase_out(fsk_phase_out),
        .fsk_sym_idx_out(fsk_sym_idx_out), .fsk_sym_strobe(fsk_sym_strobe),
        .fsk_busy(fsk_busy), .fsk_underrun(fsk_underrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: bits waiting in a queue, tone index, phase as modular sum.
    logic [FW-1:0] m_ftw [1<<B];
    logic [FW-1:0] m_phase;
    logic [PW-1:0] m_pout;
    int            m_cnt;
    int            bitq[$];
    int            m_idx;
    bit            m_busy, m_strobe, m_und, last_acc;

    typedef struct {
        logic [1:0] bits;
        int         exp_bin;
        int         exp_gray;
    } vec_t;
    vec_t vecs[4];

    function automatic int decode(input int g);
        int b;
        b = g;
`ifdef MFSK_GRAY_EN
        for (int s = 1; s < B; s++) b = b ^ (g >> s);
`endif
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < (1<<B); i++) m_ftw[i] = '0;
        m_phase = '0; m_pout = '0; m_cnt = 0; bitq.delete();
        m_idx = 0; m_busy = 0; m_strobe = 0; m_und = 0; last_acc = 0;
    endtask

    task automatic model_step();
        bit rdy, bnd;
        int sym;
        rdy = en && (bitq.size() < B);
        last_acc = m_ser_valid && rdy;
        bnd = 0; m_strobe = 0; m_und = 0;
        if (en) begin
            m_pout  = m_phase[FW-1 -: PW];
            m_phase = m_phase + m_ftw[m_idx];
            bnd     = (m_cnt == SC - 1);
            m_cnt   = (m_cnt + 1) % SC;
        end
        if (bnd) begin
            if (bitq.size() >= B) begin
                sym = 0;
                for (int i = 0; i < B; i++) sym = sym * 2 + bitq.pop_front();
                m_idx = decode(sym); m_busy = 1; m_strobe = 1;
            end else begin
                m_idx = 0; m_busy = 0; m_und = 1;
            end
        end
        if (last_acc) bitq.push_back(int'(m_ser_code_in));
        if (ftw_wr) m_ftw[ftw_addr] = ftw_data;
    endtask

    task automatic check_outs(input string name);
        logic [PW+B+2:0] act, exp;
        act = {fsk_phase_out, fsk_sym_idx_out, fsk_sym_strobe, fsk_busy, fsk_underrun};
        exp = {m_pout, B'(m_idx), m_strobe, m_busy, m_und};
        check(name, 32'(act), 32'(exp));
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after it.
    task automatic cycle(input string name);
        #1;
        check({name, "_ready"}, 32'(m_ser_ready), 32'(en && rst_n && (bitq.size() < B)));
        model_step();
        @(posedge clk);
        #1;
        check_outs(name);
    endtask

    task automatic set_in(input logic e, input logic v, input logic b);
        en = e; m_ser_valid = v; m_ser_code_in = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ftw_wr = 1'b0; ftw_addr = '0; ftw_data = '0;
        set_in(1'b0, 1'b0, 1'b0);
        #1;
        check("rst_outs", 32'({m_ser_ready, fsk_phase_out, fsk_sym_idx_out,
                               fsk_sym_strobe, fsk_busy, fsk_underrun}), 32'd0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic wr_ftw(input logic [B-1:0] a, input logic [FW-1:0] d);
        ftw_wr = 1'b1; ftw_addr = a; ftw_data = d;
        cycle("ftw_wr");
        ftw_wr = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit done;
        done = 0;
        set_in(1'b1, 1'b1, b);
        for (int i = 0; i < 4 * SC && !done; i++) begin
            cycle("send");
            done = last_acc;
        end
        m_ser_valid = 1'b0;
        check("send_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_strobe();
        bit seen;
        seen = 0;
        for (int i = 0; i < 3 * SC && !seen; i++) begin
            cycle("wait");
            seen = fsk_sym_strobe;
        end
        check("strobe_timeout", 32'(seen), 32'd1);
    endtask

    initial begin
        int cnt, e_cyc;
        logic [PW-1:0] prev;
        vecs[0] = '{2'b00, 0, 0};
        vecs[1] = '{2'b01, 1, 1};
        vecs[2] = '{2'b10, 2, 3};
        vecs[3] = '{2'b11, 3, 2};

        // Idle: underrun every SC clocks, idle tone.
        do_reset();
        set_in(1'b1, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 3 * SC; i++) begin
            cycle("idle");
            if (fsk_underrun) cnt++;
        end
        check("idle_underruns", 32'(cnt), 32'd3);

        // Symbol decode table.
        do_reset();
        for (int v = 0; v < 4; v++) begin
            send_bit(vecs[v].bits[1]);
            send_bit(vecs[v].bits[0]);
            wait_strobe();
`ifdef MFSK_GRAY_EN
            check("table_idx", 32'(fsk_sym_idx_out), 32'(vecs[v].exp_gray));
`else
            check("table_idx", 32'(fsk_sym_idx_out), 32'(vecs[v].exp_bin));
`endif
        end

        // Phase continuity: tone 1 advances phase_out by exactly 4 LSB per clock.
        do_reset();
        wr_ftw(2'd0, 24'h001000);
        wr_ftw(2'd1, 24'h010000);
        send_bit(1'b0); send_bit(1'b1);
        wait_strobe();
        cycle("cont");
        for (int k = 0; k < 6; k++) begin
            prev = fsk_phase_out;
            cycle("cont");
            check("cont_delta", 32'(fsk_phase_out - prev), 32'd4);
        end
        send_bit(1'b0); send_bit(1'b0);
        wait_strobe();
        for (int k = 0; k < SC; k++) cycle("cont_tail");

        // Wrap: all-ones FTW from phase 0.
        do_reset();
        wr_ftw(2'd2, 24'hFFFFFF);
        wr_ftw(2'd3, 24'hFFFFFF);
        send_bit(1'b1); send_bit(1'b1);
        wait_strobe();
        cycle("wrap");
        check("wrap_first", 32'(fsk_phase_out), 32'h0);
        for (int k = 0; k < 4; k++) begin
            cycle("wrap");
            check("wrap_top", 32'(fsk_phase_out), 32'h3FF);
        end

        // Backpressure: valid held high for 16 symbols.
        do_reset();
        cnt = 0;
        for (int i = 0; i < 16 * SC; i++) begin
            set_in(1'b1, 1'b1, 1'($urandom_range(0, 1)));
            cycle("bp");
            if (fsk_sym_strobe) cnt++;
        end
        check("bp_strobes", 32'(cnt), 32'd16);

        // en gating: 5 frozen cycles stretch the first symbol to 13 edges.
        do_reset();
        wr_ftw(2'd0, 24'h123457);
        e_cyc = 1;
        cnt = 0;
        for (int i = 0; i < 30 && cnt == 0; i++) begin
            set_in((i < 2 || i >= 7) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            cycle("gate");
            e_cyc = e_cyc + 1;
            if (fsk_underrun) cnt = e_cyc;
        end
        check("gate_len", 32'(cnt), 32'd14);

        // Randomized traffic with occasional FTW writes.
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            ftw_wr   = 1'($urandom_range(0, 19) == 0);
            ftw_addr = B'($urandom_range(0, 3));
            ftw_data = FW'($urandom);
            cycle("rand");
        end
        ftw_wr = 1'b0;

        // Asynchronous reset mid-symbol.
        set_in(1'b1, 1'b1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", 32'({m_ser_ready, fsk_phase_out, fsk_sym_idx_out,
                                fsk_sym_strobe, fsk_busy, fsk_underrun}), 32'd0);
        model_reset();
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * SC; i++) begin
            set_in(1'b1, 1'b0, 1'b0);
            cycle("post_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mfsk_modulator.md
Name: mfsk_modulator

Overview:
- Parametrised M-ary FSK modulator, M = 2^BITS_PER_SYM.
- Accepts a serial bit stream over a valid/ready handshake and packs BITS_PER_SYM bits into each symbol.
- Holds each symbol for SYM_CYCLES clocks and drives a phase-continuous DDS phase accumulator from a writable frequency-tuning-word (FTW) table.
- Emits the truncated phase address to the downstream sine ROM. This replaces external per-tone DDS muxing, which cannot guarantee phase continuity.

Parameters:
- BITS_PER_SYM, 1, bits per symbol; tone count M = 2^BITS_PER_SYM (legal range 1..4).
- FTW_W, 24, phase accumulator and FTW width.
- PHASE_OUT_W, 10, phase address width to the sine ROM; must be <= FTW_W.
- SYM_CYCLES, 1000, clocks per symbol; must be >= BITS_PER_SYM+2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; when low, all state holds and m_ser_ready=0.
- ftw_wr  in  1  FTW table write strobe.
- ftw_addr  in  BITS_PER_SYM  FTW table entry index.
- ftw_data  in  FTW_W  FTW value to write.
- m_ser_code_in  in  1  serial data bit.
- m_ser_valid  in  1  m_ser_code_in is valid.
- m_ser_ready  out  1  block accepts a bit this cycle.
- fsk_phase_out  out  PHASE_OUT_W  registered phase address, equal to phase_acc[FTW_W-1 -: PHASE_OUT_W].
- fsk_sym_idx_out  out  BITS_PER_SYM  tone index currently in use.
- fsk_sym_strobe  out  1  one-cycle pulse when a data symbol is loaded.
- fsk_busy  out  1  current symbol is data (not idle tone).
- fsk_underrun  out  1  one-cycle pulse when a boundary is reached with no complete symbol.

Behaviour:
Reset:
- All outputs 0.
- phase_acc=0, sym_cnt=0, shift register and bit count cleared, next_full=0.
- All FTW table entries 0.

FTW table:
- Write takes effect on the clock edge where ftw_wr=1, independent of en.
- A write to the active index changes the phase increment from the following cycle.

Bit intake:
- m_ser_ready = en && !next_full.
- A bit is accepted when m_ser_valid && m_ser_ready and is shifted in MSB-first.
- When bit count reaches BITS_PER_SYM, next_full=1 and bit count returns to 0.

Symbol timing (sym_cnt):
- Counts 0..SYM_CYCLES-1 while en=1, wraps to 0, and holds while en=0.
- The boundary is the cycle with sym_cnt==SYM_CYCLES-1 and en=1. At the boundary:
  - If next_full: cur_idx <= next symbol (after optional decode), next_full <= 0, fsk_sym_strobe=1 next cycle, fsk_busy=1.
  - Else (underrun): cur_idx <= 0 (idle tone), fsk_busy=0, fsk_underrun=1 for one cycle. Partially collected bits are retained.
- No new bit is accepted on the transfer cycle because ready is already low there.

Phase accumulator:
- While en=1: phase_acc <= phase_acc + ftw[cur_idx], modulo 2^FTW_W (natural wrap).
- Never reset on a symbol change (continuous phase).
- fsk_phase_out updates one cycle after phase_acc.
- The new tone's FTW applies from the first cycle after the boundary.
- Latency: a symbol whose last bit is accepted in cycle t is first seen on fsk_sym_idx_out no earlier than the next boundary+1.

en deassertion mid-symbol:
- Freezes sym_cnt, phase_acc, and all outputs.
- Resumes exactly where it stopped.

Reset mid-symbol:
- Asynchronously clears everything.
- The in-flight symbol and any partial bits are discarded.

Optional Feature:
- Macro: MFSK_GRAY_EN.
- Defined: the assembled BITS_PER_SYM-bit symbol is treated as Gray code and converted to binary (b[n-1]=g[n-1], b[i]=b[i+1]^g[i]) before loading cur_idx.
- Undefined: the assembled bits load cur_idx directly.
- No port or timing change in either case.

Test Plan:
- Reset/idle: rst_n low, then en=1 with no input, SYM_CYCLES=8 -> fsk_underrun pulses every 8 clocks; fsk_sym_idx_out=0; fsk_busy=0; all outputs 0 during reset.
- Phase continuity: BITS_PER_SYM=1, FTW_W=24, ftw0=0x001000, ftw1=0x010000, bits 1,0 -> phase_acc steps by 0x010000 for 8 cycles, then by 0x001000 with no discontinuity; fsk_sym_strobe pulses at each load.
- Backpressure: hold m_ser_valid=1 continuously -> m_ser_ready drops after each complete symbol and rises 1 cycle after the boundary transfer; no bit lost or duplicated over 16 symbols.
- Wrap: ftw1=0xFFFFFF, symbol 1 for 4 cycles from phase_acc=0 -> phase_acc = 0xFFFFFF, 0xFFFFFE, 0xFFFFFD, 0xFFFFFC; fsk_phase_out tracks the top 10 bits one cycle later.
- en gating and reset: drop en for 5 cycles mid-symbol -> sym_cnt and phase frozen, symbol length still 8 enabled clocks; assert rst_n=0 mid-symbol -> all outputs 0 immediately.
- Gray (MFSK_GRAY_EN, BITS_PER_SYM=2): input bits 1,1 -> fsk_sym_idx_out=2; without the macro -> 3.
